// File: rtl/complex_pkg.sv
// Shared definitions for the complex half-vector assembler and its companion demux.
package complex_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } asm_state_e;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/complex_half_reg.sv
// Enable-loaded holding register for one half-vector, async active-low reset.
module complex_half_reg #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/complex_half_vector_assembler.sv
// Collects two half-vectors into one complex vector with valid/ready output.
// Define COMPLEX_ASM_OVERLAP_EN to accept the next low half while the full vector drains.
module complex_half_vector_assembler
  import complex_pkg::*;
#(
  parameter int NI            = 8,
  parameter int element_width = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [element_width*(NI/2)-1:0]      in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic                                 half_sel,
  input  logic                                 flush,
  output logic [2*element_width*(NI/2)-1:0]    out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int HW = element_width * (NI / 2);

  asm_state_e    state_q;
  asm_state_e    state_d;
  logic          lo_en;
  logic          hi_en;
  logic [HW-1:0] lo_q;
  logic [HW-1:0] hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    half_sel  = HALF_LO;
    lo_en     = 1'b0;
    hi_en     = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lo_en   = 1'b1;
          state_d = HALF;
        end
      end
      HALF: begin
        // flush wins over a same-cycle input; the stale low half is simply overwritten later
        in_ready = !flush;
        half_sel = HALF_HI;
        if (flush) begin
          state_d = EMPTY;
        end else if (in_valid) begin
          hi_en   = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        out_valid = 1'b1;
`ifdef COMPLEX_ASM_OVERLAP_EN
        in_ready = out_ready;
        if (out_ready) begin
          lo_en   = in_valid;
          state_d = in_valid ? HALF : EMPTY;
        end
`else
        if (out_ready) state_d = EMPTY;
`endif
      end
      default: state_d = EMPTY;
    endcase
  end

  complex_half_reg #(.WIDTH(HW)) u_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lo_en),
    .d     (in_data),
    .q     (lo_q)
  );

  complex_half_reg #(.WIDTH(HW)) u_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hi_en),
    .d     (in_data),
    .q     (hi_q)
  );

  assign out_data = {hi_q, lo_q};

endmodule

// File: tb/tb_complex_half_vector_assembler.sv
// Scoreboard bench for complex_half_vector_assembler (NI=8, 64-bit elements).
module tb_complex_half_vector_assembler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         half_sel;
  logic         flush = 1'b0;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [511:0] exp_q[$];
  int out_cyc[$];

  complex_half_vector_assembler #(.NI(8), .element_width(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .half_sel  (half_sel),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: an output transfer happens on the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [255:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk("send_timeout", 512'(in_ready), 512'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 512'(exp_q.size()), 512'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] lo [4];
    logic [255:0] hi [4];

    // Reset values
    #2;
    chk("rst_out_valid", 512'(out_valid), 512'd0);
    chk("rst_out_data",  out_data, '0);
    chk("rst_in_ready",  512'(in_ready), 512'd1);
    chk("rst_half_sel",  512'(half_sel), 512'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic assembly
    out_ready = 1'b1;
    chk("basic_sel0", 512'(half_sel), 512'd0);
    send(256'hA);
    chk("basic_sel1", 512'(half_sel), 512'd1);
    chk("basic_valid_lo", 512'(out_valid), 512'd0);
    send(256'hB);
    exp_q.push_back({256'hB, 256'hA});
    idle();
    chk("basic_sel2", 512'(half_sel), 512'd0);
    chk("basic_latency", 512'(out_valid), 512'd1);
    drain();
    chk("basic_back_empty", 512'(out_valid), 512'd0);

    // Backpressure
    out_ready = 1'b0;
    send(256'h1111);
    send(256'h2222);
    in_data = 256'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 512'(out_valid), 512'd1);
      chk("bp_data", out_data, {256'h2222, 256'h1111});
      chk("bp_in_ready", 512'(in_ready), 512'd0);
    end
    idle();
    exp_q.push_back({256'h2222, 256'h1111});
    out_ready = 1'b1;
    drain();

    // Flush in HALF with same-cycle input
    send(256'hA);
    idle();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 256'hC;
    @(negedge clk);
    chk("flush_in_ready", 512'(in_ready), 512'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    chk("flush_sel", 512'(half_sel), 512'd0);
    chk("flush_valid", 512'(out_valid), 512'd0);
    send(256'hD);
    send(256'hE);
    exp_q.push_back({256'hE, 256'hD});
    idle();
    drain();

    // Reset mid-vector
    send(256'hA);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_valid", 512'(out_valid), 512'd0);
    chk("amid_data",  out_data, '0);
    chk("amid_sel",   512'(half_sel), 512'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back stream
    lo[0] = 256'h10; hi[0] = 256'h11;
    lo[1] = 256'h20; hi[1] = 256'h21;
    lo[2] = 256'h30; hi[2] = 256'h31;
    lo[3] = 256'h40; hi[3] = 256'h41;
    out_cyc.delete();
    for (int v = 0; v < 4; v++) begin
      send(lo[v]);
      send(hi[v]);
      exp_q.push_back({hi[v], lo[v]});
    end
    idle();
    drain();
    chk("stream_count", 512'(out_cyc.size()), 512'd4);
    if (out_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
`ifdef COMPLEX_ASM_OVERLAP_EN
        chk("stream_interval", 512'(out_cyc[i] - out_cyc[i-1]), 512'd2);
`else
        chk("stream_interval", 512'(out_cyc[i] - out_cyc[i-1]), 512'd3);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
